// File: rtl/id_ex_ctl_stage_if.sv
// Decode-to-execute control bundle interface: decode-side inputs, EX-side
// registered outputs, interlock stall and bubble counter.
interface id_ex_ctl_stage_if #(
  parameter int CNT_W = 16
);
  logic             id_valid_i;
  logic [1:0]       pc_sel_i;
  logic             op1sel_i;
  logic [1:0]       op2sel_i;
  logic [1:0]       wb_sel_i;
  logic             pc4_sel_i;
  logic             mem_wr_i;
  logic             cpr_en_i;
  logic             rf_en_i;
  logic [5:0]       alu_fun_i;
  logic [4:0]       rd_i;
  logic [4:0]       rs1_i;
  logic [4:0]       rs2_i;
  logic             rs1_used_i;
  logic             rs2_used_i;
  logic             flush_i;
  logic             mem_stall_i;
  logic             ex_valid_o;
  logic [1:0]       ex_pc_sel_o;
  logic             ex_op1sel_o;
  logic [1:0]       ex_op2sel_o;
  logic [1:0]       ex_wb_sel_o;
  logic             ex_pc4_sel_o;
  logic             ex_mem_wr_o;
  logic             ex_cpr_en_o;
  logic             ex_rf_en_o;
  logic [5:0]       ex_alu_fun_o;
  logic [4:0]       ex_rd_o;
  logic             stall_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output id_valid_i, pc_sel_i, op1sel_i, op2sel_i, wb_sel_i, pc4_sel_i,
           mem_wr_i, cpr_en_i, rf_en_i, alu_fun_i, rd_i, rs1_i, rs2_i,
           rs1_used_i, rs2_used_i, flush_i, mem_stall_i,
    input  ex_valid_o, ex_pc_sel_o, ex_op1sel_o, ex_op2sel_o, ex_wb_sel_o,
           ex_pc4_sel_o, ex_mem_wr_o, ex_cpr_en_o, ex_rf_en_o, ex_alu_fun_o,
           ex_rd_o, stall_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, pc_sel_i, op1sel_i, op2sel_i, wb_sel_i, pc4_sel_i,
           mem_wr_i, cpr_en_i, rf_en_i, alu_fun_i, rd_i, rs1_i, rs2_i,
           rs1_used_i, rs2_used_i, flush_i, mem_stall_i,
    output ex_valid_o, ex_pc_sel_o, ex_op1sel_o, ex_op2sel_o, ex_wb_sel_o,
           ex_pc4_sel_o, ex_mem_wr_o, ex_cpr_en_o, ex_rf_en_o, ex_alu_fun_o,
           ex_rd_o, stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_ctl_stage.sv
// ID/EX pipeline register for the decoded control bundle, with load-use
// interlock, flush squashing, memory-stall hold and a saturating bubble counter.
module id_ex_ctl_stage #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  id_ex_ctl_stage_if.slave bus
);
  localparam int CTL_W = 17;

  // Bundle layout: pc_sel[16:15] op1sel[14] op2sel[13:12] wb_sel[11:10]
  // pc4_sel[9] mem_wr[8] cpr_en[7] rf_en[6] alu_fun[5:0]
  logic [CTL_W-1:0] ctl_r;
  logic [CTL_W-1:0] ctl_in_s;
  logic             valid_r;
  logic [4:0]       rd_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ex_load_s;
  logic             load_use_s;
  logic             bubble_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign ctl_in_s = {bus.pc_sel_i, bus.op1sel_i, bus.op2sel_i, bus.wb_sel_i,
                     bus.pc4_sel_i, bus.mem_wr_i, bus.cpr_en_i, bus.rf_en_i,
                     bus.alu_fun_i};

  // Load-use hazard detection against the instruction currently in EX
  always_comb begin
    ex_load_s  = valid_r & ctl_r[6] & (ctl_r[11:10] == 2'b00);
    load_use_s = bus.id_valid_i & ex_load_s & (rd_r != 5'd0) &
                 ((bus.rs1_used_i & (bus.rs1_i == rd_r)) |
                  (bus.rs2_used_i & (bus.rs2_i == rd_r)));
    bubble_s   = bus.flush_i | load_use_s;
  end

  // A flush squashes the dependent instruction, so it never needs holding
  assign bus.stall_o = bus.mem_stall_i | (load_use_s & ~bus.flush_i);

  // EX register update: memory stall holds, flush/load-use insert a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_r   <= {CTL_W{1'b0}};
      valid_r <= 1'b0;
      rd_r    <= 5'd0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (bus.mem_stall_i) begin
      ctl_r   <= ctl_r;
      valid_r <= valid_r;
      rd_r    <= rd_r;
      cnt_r   <= cnt_r;
    end else if (bubble_s) begin
      ctl_r   <= {CTL_W{1'b0}};
      valid_r <= 1'b0;
      rd_r    <= 5'd0;
      cnt_r   <= sat_inc(cnt_r);
    end else if (bus.id_valid_i) begin
      ctl_r   <= ctl_in_s;
      valid_r <= 1'b1;
      rd_r    <= bus.rd_i;
      cnt_r   <= cnt_r;
    end else begin
      ctl_r   <= {CTL_W{1'b0}};
      valid_r <= 1'b0;
      rd_r    <= 5'd0;
      cnt_r   <= cnt_r;
    end
  end

  assign bus.ex_valid_o   = valid_r;
  assign bus.ex_pc_sel_o  = ctl_r[16:15];
  assign bus.ex_op1sel_o  = ctl_r[14];
  assign bus.ex_op2sel_o  = ctl_r[13:12];
  assign bus.ex_wb_sel_o  = ctl_r[11:10];
  assign bus.ex_pc4_sel_o = ctl_r[9];
  assign bus.ex_mem_wr_o  = ctl_r[8];
  assign bus.ex_cpr_en_o  = ctl_r[7];
  assign bus.ex_rf_en_o   = ctl_r[6];
  assign bus.ex_alu_fun_o = ctl_r[5:0];
  assign bus.ex_rd_o      = rd_r;
  assign bus.bubble_cnt_o = cnt_r;
endmodule

// File: tb/tb_id_ex_ctl_stage.sv
// Self-checking bench for id_ex_ctl_stage: directed scenarios plus random
// traffic compared against a transaction-level model of the EX stage.
module tb_id_ex_ctl_stage;
  typedef struct packed {
    logic [1:0] pc_sel;
    logic       op1sel;
    logic [1:0] op2sel;
    logic [1:0] wb_sel;
    logic       pc4_sel;
    logic       mem_wr;
    logic       cpr_en;
    logic       rf_en;
    logic [5:0] alu_fun;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  // Decode-side stimulus
  ctl_t       d_ctl;
  logic       d_valid, d_u1, d_u2, d_flush, d_mstall;
  logic [4:0] d_rd, d_rs1, d_rs2;

  // Reference model of what EX holds
  ctl_t       m_ctl;
  logic       m_valid;
  logic [4:0] m_rd;
  int         m_cnt;

  always #5 clk = ~clk;

  id_ex_ctl_stage_if #(.CNT_W(16)) bus ();
  id_ex_ctl_stage_if #(.CNT_W(2))  bus2 ();

  id_ex_ctl_stage #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  id_ex_ctl_stage #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  assign bus2.id_valid_i  = bus.id_valid_i;
  assign bus2.pc_sel_i    = bus.pc_sel_i;
  assign bus2.op1sel_i    = bus.op1sel_i;
  assign bus2.op2sel_i    = bus.op2sel_i;
  assign bus2.wb_sel_i    = bus.wb_sel_i;
  assign bus2.pc4_sel_i   = bus.pc4_sel_i;
  assign bus2.mem_wr_i    = bus.mem_wr_i;
  assign bus2.cpr_en_i    = bus.cpr_en_i;
  assign bus2.rf_en_i     = bus.rf_en_i;
  assign bus2.alu_fun_i   = bus.alu_fun_i;
  assign bus2.rd_i        = bus.rd_i;
  assign bus2.rs1_i       = bus.rs1_i;
  assign bus2.rs2_i       = bus.rs2_i;
  assign bus2.rs1_used_i  = bus.rs1_used_i;
  assign bus2.rs2_used_i  = bus.rs2_used_i;
  assign bus2.flush_i     = bus.flush_i;
  assign bus2.mem_stall_i = bus.mem_stall_i;

  function automatic ctl_t ex_ctl();
    ctl_t c;
    c = {bus.ex_pc_sel_o, bus.ex_op1sel_o, bus.ex_op2sel_o, bus.ex_wb_sel_o,
         bus.ex_pc4_sel_o, bus.ex_mem_wr_o, bus.ex_cpr_en_o, bus.ex_rf_en_o,
         bus.ex_alu_fun_o};
    return c;
  endfunction

  // True when EX holds a real load into a nonzero register the decoded
  // instruction actually reads.
  function automatic bit model_hazard();
    bit is_load, reads;
    is_load = m_valid && m_ctl.rf_en && (m_ctl.wb_sel == 2'b00);
    reads   = (d_u1 && d_rs1 == m_rd) || (d_u2 && d_rs2 == m_rd);
    return d_valid && is_load && (m_rd != 5'd0) && reads;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic clear_decode();
    d_ctl = '0; d_valid = 1'b0; d_u1 = 1'b0; d_u2 = 1'b0;
    d_flush = 1'b0; d_mstall = 1'b0; d_rd = 5'd0; d_rs1 = 5'd0; d_rs2 = 5'd0;
  endtask

  task automatic model_clear();
    m_ctl = '0; m_valid = 1'b0; m_rd = 5'd0; m_cnt = 0;
  endtask

  task automatic drive_settle(input string tag);
    bit exp_stall;
    {bus.pc_sel_i, bus.op1sel_i, bus.op2sel_i, bus.wb_sel_i, bus.pc4_sel_i,
     bus.mem_wr_i, bus.cpr_en_i, bus.rf_en_i, bus.alu_fun_i} = d_ctl;
    bus.id_valid_i = d_valid;  bus.rd_i = d_rd;
    bus.rs1_i = d_rs1;         bus.rs2_i = d_rs2;
    bus.rs1_used_i = d_u1;     bus.rs2_used_i = d_u2;
    bus.flush_i = d_flush;     bus.mem_stall_i = d_mstall;
    #1;
    exp_stall = d_mstall || (model_hazard() && !d_flush);
    checks++;
    if (bus.stall_o !== exp_stall) begin
      failures++;
      $display("FAIL %s stall: got %b want %b", tag, bus.stall_o, exp_stall);
    end
  endtask

  task automatic clock_check(input string tag);
    bit hz;
    hz = model_hazard();
    @(posedge clk);
    if (d_mstall) begin
      // EX contents freeze
    end else if (d_flush || hz) begin
      m_ctl = '0; m_valid = 1'b0; m_rd = 5'd0; m_cnt++;
    end else if (d_valid) begin
      m_ctl = d_ctl; m_valid = 1'b1; m_rd = d_rd;
    end else begin
      m_ctl = '0; m_valid = 1'b0; m_rd = 5'd0;
    end
    #1;
    checks++;
    if (bus.ex_valid_o !== m_valid) begin
      failures++;
      $display("FAIL %s valid: got %b want %b", tag, bus.ex_valid_o, m_valid);
    end
    checks++;
    if (ex_ctl() !== m_ctl) begin
      failures++;
      $display("FAIL %s ctl: got %h want %h", tag, ex_ctl(), m_ctl);
    end
    if (m_valid) begin
      checks++;
      if (bus.ex_rd_o !== m_rd) begin
        failures++;
        $display("FAIL %s rd: got %0d want %0d", tag, bus.ex_rd_o, m_rd);
      end
    end
    checks++;
    if (int'(bus.bubble_cnt_o) != sat(m_cnt, 65535)) begin
      failures++;
      $display("FAIL %s cnt16: got %0d want %0d", tag, bus.bubble_cnt_o, sat(m_cnt, 65535));
    end
    checks++;
    if (int'(bus2.bubble_cnt_o) != sat(m_cnt, 3)) begin
      failures++;
      $display("FAIL %s cnt2: got %0d want %0d", tag, bus2.bubble_cnt_o, sat(m_cnt, 3));
    end
  endtask

  task automatic tick(input string tag);
    drive_settle(tag);
    clock_check(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    clear_decode();
    drive_settle("rst_in");
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    clear_decode();
    d_valid = 1'b1; d_ctl.rf_en = 1'b1; d_ctl.wb_sel = 2'b00; d_ctl.op2sel = 2'b01;
    d_rd = rd;
  endtask

  task automatic set_add(input logic [4:0] rd);
    clear_decode();
    d_valid = 1'b1; d_ctl.op2sel = 2'b11; d_ctl.wb_sel = 2'b01; d_ctl.rf_en = 1'b1;
    d_ctl.alu_fun = 6'b000000; d_rd = rd;
  endtask

  task automatic set_store();
    clear_decode();
    d_valid = 1'b1; d_ctl.mem_wr = 1'b1; d_ctl.op2sel = 2'b10; d_rs1 = 5'd2;
    d_rs2 = 5'd3; d_u1 = 1'b1; d_u2 = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_decode();
    model_clear();
    #12;
    drive_settle("reset");
    checks++;
    if (bus.ex_valid_o !== 1'b0 || ex_ctl() !== '0 || bus.ex_rd_o !== 5'd0 ||
        bus.bubble_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b ctl=%h rd=%0d cnt=%0d want all 0",
               bus.ex_valid_o, ex_ctl(), bus.ex_rd_o, bus.bubble_cnt_o);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_pass_through();
    set_add(5'd5);
    tick("pass");
    checks++;
    if (bus.ex_rf_en_o !== 1'b1 || bus.ex_rd_o !== 5'd5 || bus.ex_valid_o !== 1'b1 ||
        bus.stall_o !== 1'b0 || bus.bubble_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL pass_fields: got rf=%b rd=%0d v=%b st=%b cnt=%0d want 1 5 1 0 0",
               bus.ex_rf_en_o, bus.ex_rd_o, bus.ex_valid_o, bus.stall_o, bus.bubble_cnt_o);
    end
  endtask

  task automatic test_load_use();
    int c0;
    set_load(5'd7);
    tick("lu_load");
    c0 = int'(bus.bubble_cnt_o);
    set_add(5'd8);
    d_rs2 = 5'd7; d_u2 = 1'b1;
    drive_settle("lu_hz");
    checks++;
    if (bus.stall_o !== 1'b1) begin
      failures++;
      $display("FAIL lu_stall: got %b want 1", bus.stall_o);
    end
    clock_check("lu_hz");
    checks++;
    if (bus.ex_valid_o !== 1'b0 || int'(bus.bubble_cnt_o) != c0 + 1) begin
      failures++;
      $display("FAIL lu_bubble: got v=%b cnt=%0d want v=0 cnt=%0d",
               bus.ex_valid_o, bus.bubble_cnt_o, c0 + 1);
    end
    drive_settle("lu_rel");
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL lu_release: got %b want 0", bus.stall_o);
    end
    clock_check("lu_rel");
    checks++;
    if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd8) begin
      failures++;
      $display("FAIL lu_capture: got v=%b rd=%0d want 1 8", bus.ex_valid_o, bus.ex_rd_o);
    end
  endtask

  task automatic test_non_hazards();
    for (int k = 0; k < 3; k++) begin
      int c0;
      if (k == 0) set_load(5'd0);
      else if (k == 1) set_load(5'd7);
      else set_add(5'd7);
      tick("nh_prod");
      c0 = int'(bus.bubble_cnt_o);
      set_add(5'd9);
      if (k == 0) begin d_rs1 = 5'd0; d_u1 = 1'b1; end
      else if (k == 1) begin d_rs2 = 5'd7; d_u2 = 1'b0; end
      else begin d_rs1 = 5'd7; d_u1 = 1'b1; end
      drive_settle("nh_cons");
      checks++;
      if (bus.stall_o !== 1'b0) begin
        failures++;
        $display("FAIL nonhazard%0d stall: got %b want 0", k, bus.stall_o);
      end
      clock_check("nh_cons");
      checks++;
      if (bus.ex_valid_o !== 1'b1 || int'(bus.bubble_cnt_o) != c0) begin
        failures++;
        $display("FAIL nonhazard%0d nobubble: got v=%b cnt=%0d want v=1 cnt=%0d",
                 k, bus.ex_valid_o, bus.bubble_cnt_o, c0);
      end
    end
  endtask

  task automatic test_flush_vs_load_use();
    int c0;
    set_load(5'd7);
    tick("fl_load");
    c0 = int'(bus.bubble_cnt_o);
    set_add(5'd4);
    d_rs1 = 5'd7; d_u1 = 1'b1; d_flush = 1'b1;
    drive_settle("fl_lu");
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_lu stall: got %b want 0", bus.stall_o);
    end
    clock_check("fl_lu");
    checks++;
    if (bus.ex_valid_o !== 1'b0 || int'(bus.bubble_cnt_o) != c0 + 1) begin
      failures++;
      $display("FAIL flush_lu count: got v=%b cnt=%0d want v=0 cnt=%0d",
               bus.ex_valid_o, bus.bubble_cnt_o, c0 + 1);
    end
    d_flush = 1'b0;
  endtask

  task automatic test_mem_stall();
    int c0;
    set_store();
    tick("ms_sw");
    c0 = int'(bus.bubble_cnt_o);
    set_add(5'd6);
    d_flush = 1'b1; d_mstall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_settle("ms_hold");
      checks++;
      if (bus.stall_o !== 1'b1) begin
        failures++;
        $display("FAIL mstall%0d stall: got %b want 1", i, bus.stall_o);
      end
      clock_check("ms_hold");
      checks++;
      if (bus.ex_mem_wr_o !== 1'b1 || int'(bus.bubble_cnt_o) != c0) begin
        failures++;
        $display("FAIL mstall%0d hold: got wr=%b cnt=%0d want wr=1 cnt=%0d",
                 i, bus.ex_mem_wr_o, bus.bubble_cnt_o, c0);
      end
    end
    d_mstall = 1'b0;
    tick("ms_flush");
    d_flush = 1'b0;
  endtask

  task automatic test_saturation();
    int exp2[5] = '{1, 2, 3, 3, 3};
    do_reset();
    clear_decode();
    d_flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("sat");
      checks++;
      if (int'(bus2.bubble_cnt_o) != exp2[i] || int'(bus.bubble_cnt_o) != i + 1) begin
        failures++;
        $display("FAIL sat%0d: got cnt2=%0d cnt16=%0d want %0d %0d",
                 i, bus2.bubble_cnt_o, bus.bubble_cnt_o, exp2[i], i + 1);
      end
    end
    d_flush = 1'b0;
  endtask

  task automatic test_async_reset();
    set_store();
    tick("ar_sw");
    set_add(5'd1);
    d_mstall = 1'b1;
    drive_settle("ar_stall");
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.ex_mem_wr_o !== 1'b0 || bus.ex_valid_o !== 1'b0 || bus.bubble_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: got wr=%b v=%b cnt=%0d want 0 0 0",
               bus.ex_mem_wr_o, bus.ex_valid_o, bus.bubble_cnt_o);
    end
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    set_add(5'd2);
    d_rs1 = 5'd0; d_u1 = 1'b1;
    drive_settle("ar_after");
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset residual stall: got %b want 0", bus.stall_o);
    end
    clock_check("ar_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      d_ctl    = ctl_t'($urandom);
      d_valid  = ($urandom_range(0, 7) != 0);
      d_rd     = 5'($urandom_range(0, 3));
      d_rs1    = 5'($urandom_range(0, 3));
      d_rs2    = 5'($urandom_range(0, 3));
      d_u1     = 1'($urandom_range(0, 1));
      d_u2     = 1'($urandom_range(0, 1));
      d_flush  = ($urandom_range(0, 7) == 0);
      d_mstall = ($urandom_range(0, 5) == 0);
      tick("rand");
    end
    clear_decode();
  endtask

  initial begin
    clear_decode();
    model_clear();
    test_reset();
    test_pass_through();
    test_load_use();
    test_non_hazards();
    test_flush_vs_load_use();
    test_mem_stall();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
